dcache_2way_wb: RTL

- Two-way set-associative, write-back, write-allocate cache.
- Sits between a MIPS pipeline memory port (instruction or data side) and the slow 128-bit block memory.
- Serves single-word processor reads and writes, and stalls the pipeline while it evicts dirty blocks and refills lines from memory.
- Block = 4 words (128 bits). One LRU bit per set.

---
 rtl/dcache_2way_wb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dcache_2way_wb.sv
// Two-way set-associative, write-back, write-allocate cache between a pipeline memory port and 128-bit block memory.
// Optional macro CACHE_CRITICAL_WORD_EN: a read miss is answered from mem_rdata in the refill cycle itself.
module dcache_2way_wb #(
  parameter int SET_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int TAG_BITS = 28 - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_next;

  logic                valid_q [2][SETS];
  logic                dirty_q [2][SETS];
  logic                lru_q   [SETS];
  logic [TAG_BITS-1:0] tag_q   [2][SETS];
  logic [127:0]        data_q  [2][SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag_in;
  logic [1:0]          word;
  logic                req, hit0, hit1, hit, hit_way, victim;
  logic                hit_access, fill_done, cw_serve;

  assign idx        = proc_addr[SET_BITS+1:2];
  assign tag_in     = proc_addr[29:SET_BITS+2];
  assign word       = proc_addr[1:0];
  assign req        = proc_read | proc_write;
  assign hit0       = valid_q[0][idx] && (tag_q[0][idx] == tag_in);
  assign hit1       = valid_q[1][idx] && (tag_q[1][idx] == tag_in);
  assign hit        = hit0 | hit1;
  assign hit_way    = hit1;
  // Invalid ways are filled before anything is evicted; the choice stays stable for the whole miss.
  assign victim     = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign hit_access = (state == IDLE) && req && hit;
  assign fill_done  = (state == ALLOCATE) && mem_ready;

`ifdef CACHE_CRITICAL_WORD_EN
  assign cw_serve = fill_done && !proc_write;
`else
  assign cw_serve = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req && !hit)
          state_next = (valid_q[victim][idx] && dirty_q[victim][idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (mem_ready) state_next = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[29:2];
    mem_wdata  = data_q[victim][idx];
    proc_rdata = data_q[hit_way][idx][{word, 5'b0} +: 32];
    unique case (state)
      IDLE: proc_stall = req && !hit;
      WRITEBACK: begin
        mem_write  = 1'b1;
        proc_stall = 1'b1;
        mem_addr   = {tag_q[victim][idx], idx};
      end
      ALLOCATE: begin
        mem_read   = 1'b1;
        proc_stall = !cw_serve;
        if (cw_serve) proc_rdata = mem_rdata[{word, 5'b0} +: 32];
      end
      default: ;
    endcase
  end

  // Line status; a reset discards every line, dirty or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        dirty_q[0][s] <= 1'b0;
        dirty_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
    end else if (hit_access) begin
      lru_q[idx] <= ~hit_way;
      if (proc_write) dirty_q[hit_way][idx] <= 1'b1;
    end else if (fill_done) begin
      valid_q[victim][idx] <= 1'b1;
      dirty_q[victim][idx] <= 1'b0;
      if (cw_serve) lru_q[idx] <= ~victim;
    end
  end

  always_ff @(posedge clk) begin
    if (hit_access && proc_write) begin
      data_q[hit_way][idx][{word, 5'b0} +: 32] <= proc_wdata;
    end else if (fill_done) begin
      data_q[victim][idx] <= mem_rdata;
      tag_q[victim][idx]  <= tag_in;
    end
  end

endmodule
